// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - run-state sequencer: tick prescaler, countdown, pause, game over, high score
module game_sequencer #(
    parameter int TICK_DIV        = 10_000_000,
    parameter int TICKS_PER_SEC   = 10,
    parameter int COUNT_SECS      = 3,
    parameter int OVER_HOLD_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        mode_in,
    input  logic        fail,
    input  logic [15:0] score,
    output logic        engine_rst_n,
    output logic        step,
    output logic [2:0]  state,
    output logic [3:0]  countdown,
    output logic        mode,
    output logic [15:0] high_score,
    output logic        new_record
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (OVER_HOLD_TICKS > 0) ? $clog2(OVER_HOLD_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    countdown_q, countdown_d;
    logic          mode_q, mode_d;
    logic [15:0]   high_score_q, high_score_d;
    logic          new_record_q, new_record_d;
    logic          engine_rst_n_q, engine_rst_n_d;
    logic          step_q, step_d;
    logic          start_q, pause_q;

    logic tick, start_rise, pause_rise;

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;

    always_comb begin
        state_d        = state_q;
        presc_d        = tick ? '0 : presc_q + 1'b1;
        sub_d          = sub_q;
        hold_d         = hold_q;
        countdown_d    = countdown_q;
        mode_d         = mode_q;
        high_score_d   = high_score_q;
        new_record_d   = new_record_q;
        engine_rst_n_d = engine_rst_n_q;
        step_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d     = S_COUNT;
                    mode_d      = mode_in;
                    countdown_d = 4'(COUNT_SECS);
                    sub_d       = '0;
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (sub_q == SW'(TICKS_PER_SEC - 1)) begin
                        sub_d       = '0;
                        countdown_d = countdown_q - 4'd1;
                        if (countdown_q == 4'd1) begin
                            state_d        = S_PLAY;
                            engine_rst_n_d = 1'b1;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                step_d = tick & ~fail & ~pause_rise;
                if (fail) begin
                    state_d = S_OVER;
                    hold_d  = HW'(OVER_HOLD_TICKS);
                    if (score > high_score_q) begin
                        high_score_d = score;
                        new_record_d = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                    end
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_rise) begin
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                // Engine is left out of reset so the crash scene stays on screen
                if (start_rise && hold_q == '0) begin
                    state_d        = S_COUNT;
                    mode_d         = mode_in;
                    countdown_d    = 4'(COUNT_SECS);
                    sub_d          = '0;
                    engine_rst_n_d = 1'b0;
                    new_record_d   = 1'b0;
                end else if (tick && hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            presc_q        <= '0;
            sub_q          <= '0;
            hold_q         <= '0;
            countdown_q    <= 4'd0;
            mode_q         <= 1'b0;
            high_score_q   <= 16'd0;
            new_record_q   <= 1'b0;
            engine_rst_n_q <= 1'b0;
            step_q         <= 1'b0;
            // Buttons held through reset must not register as a press
            start_q        <= 1'b1;
            pause_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            sub_q          <= sub_d;
            hold_q         <= hold_d;
            countdown_q    <= countdown_d;
            mode_q         <= mode_d;
            high_score_q   <= high_score_d;
            new_record_q   <= new_record_d;
            engine_rst_n_q <= engine_rst_n_d;
            step_q         <= step_d;
            start_q        <= start;
            pause_q        <= pause;
        end
    end

    assign engine_rst_n = engine_rst_n_q;
    assign step         = step_q;
    assign state        = state_q;
    assign countdown    = countdown_q;
    assign mode         = mode_q;
    assign high_score   = high_score_q;
    assign new_record   = new_record_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, pause, mode_in, fail;
    logic [15:0] score;
    logic        engine_rst_n, step, mode, new_record;
    logic [2:0]  state;
    logic [3:0]  countdown;
    logic [15:0] high_score;

    int n_checks = 0;
    int n_fail   = 0;
    int m;
    int ticks_seen = 0;

    game_sequencer #(
        .TICK_DIV(4), .TICKS_PER_SEC(2), .COUNT_SECS(3), .OVER_HOLD_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .mode_in(mode_in),
        .fail(fail), .score(score), .engine_rst_n(engine_rst_n), .step(step),
        .state(state), .countdown(countdown), .mode(mode),
        .high_score(high_score), .new_record(new_record)
    );

    always #5 clk = ~clk;

    // Reference prescaler: m==3 marks a tick cycle
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 0;
        else     m <= (m == 3) ? 0 : m + 1;
    end

    always @(posedge clk) begin
        if (!rst && m == 3) ticks_seen <= ticks_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int k = 0;
        while (state != s && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_ticks(input int base, input int n);
        int k = 0;
        while (ticks_seen - base < n && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_cd"}, 32'(countdown), 32'd0);
        check_eq({tag, "_eng"}, 32'(engine_rst_n), 32'd0);
        check_eq({tag, "_step"}, 32'(step), 32'd0);
        check_eq({tag, "_mode"}, 32'(mode), 32'd0);
        check_eq({tag, "_hs"}, 32'(high_score), 32'd0);
        check_eq({tag, "_nr"}, 32'(new_record), 32'd0);
    endtask

    initial begin
        int ticks, n, t2, t1, t0, prev_cd, steps, first, nstep, base, k;
        logic prev_step, dbl, eng_bad;

        rst = 1'b1; start = 1'b1; pause = 1'b0; mode_in = 1'b0; fail = 1'b0; score = 16'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // 1: start held through reset is ignored; fresh press begins countdown
        repeat (4) @(negedge clk);
        check_eq("held_start_state", 32'(state), 32'd0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("count_state", 32'(state), 32'd1);
        check_eq("count_init", 32'(countdown), 32'd3);
        ticks = 0; n = 0; t2 = -100; t1 = -50; t0 = 0; prev_cd = 3; eng_bad = 1'b0;
        while (state == 3'd1 && n < 100) begin
            if (engine_rst_n) eng_bad = 1'b1;
            if (m == 3) ticks++;
            @(negedge clk);
            n++;
            if (32'(countdown) != prev_cd) begin
                if (countdown == 4'd2) t2 = n;
                if (countdown == 4'd1) t1 = n;
                if (countdown == 4'd0) t0 = n;
                prev_cd = 32'(countdown);
            end
        end
        check_eq("play_entry", 32'(state), 32'd2);
        check_eq("count_ticks", 32'(ticks), 32'd6);
        check_eq("gap_2_1", 32'(t1 - t2), 32'd8);
        check_eq("gap_1_0", 32'(t0 - t1), 32'd8);
        check_eq("eng_low_in_count", 32'(eng_bad), 32'd0);
        check_eq("eng_rise_at_play", 32'(engine_rst_n), 32'd1);
        check_eq("cd_zero_in_play", 32'(countdown), 32'd0);

        // 2: step cadence, then pause/resume
        steps = 0; first = -1; dbl = 1'b0; prev_step = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (step) begin
                steps++;
                if (first < 0) first = i;
                if (prev_step) dbl = 1'b1;
            end
            prev_step = step;
        end
        check_eq("step_count", 32'(steps), 32'd10);
        check_eq("first_step", 32'(first), 32'd4);
        check_eq("step_width", 32'(dbl), 32'd0);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check_eq("pause_state", 32'(state), 32'd3);
        nstep = 0;
        repeat (12) begin
            @(negedge clk);
            if (step) nstep++;
        end
        check_eq("pause_no_step", 32'(nstep), 32'd0);
        check_eq("pause_holds", 32'(state), 32'd3);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check_eq("resume_state", 32'(state), 32'd2);
        k = 0;
        while (!step && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_eq("step_resume", 32'(step), 32'd1);

        // 3: first failure sets a record
        score = 16'd7; fail = 1'b1;
        @(negedge clk);
        fail = 1'b0;
        base = ticks_seen;
        check_eq("over_state", 32'(state), 32'd4);
        check_eq("hs_7", 32'(high_score), 32'd7);
        check_eq("nr_set", 32'(new_record), 32'd1);

        // 4: start during hold is dropped; after hold it restarts the round
        wait_ticks(base, 1);
        start = 1'b1; mode_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_held_off", 32'(state), 32'd4);
        wait_ticks(base, 3);
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk);
        start = 1'b0; mode_in = 1'b0;
        check_eq("restart_state", 32'(state), 32'd1);
        check_eq("restart_eng", 32'(engine_rst_n), 32'd0);
        check_eq("restart_nr", 32'(new_record), 32'd0);
        check_eq("restart_mode", 32'(mode), 32'd1);
        check_eq("restart_cd", 32'(countdown), 32'd3);
        wait_state(3'd2, 100, "round2_play");
        score = 16'd7; fail = 1'b1;
        @(negedge clk);
        fail = 1'b0;
        base = ticks_seen;
        check_eq("over2_state", 32'(state), 32'd4);
        check_eq("hs_equal_keeps", 32'(high_score), 32'd7);
        check_eq("nr_equal_clear", 32'(new_record), 32'd0);
        check_eq("mode_held", 32'(mode), 32'd1);

        // 5: fail and pause together on a tick cycle
        wait_ticks(base, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(3'd2, 100, "round3_play");
        k = 0;
        while (m != 3 && k < 8) begin
            @(negedge clk);
            k++;
        end
        fail = 1'b1; pause = 1'b1; score = 16'd3;
        @(negedge clk);
        fail = 1'b0; pause = 1'b0;
        check_eq("fail_prio_state", 32'(state), 32'd4);
        check_eq("fail_prio_step", 32'(step), 32'd0);
        check_eq("fail_prio_hs", 32'(high_score), 32'd7);
        check_eq("fail_prio_nr", 32'(new_record), 32'd0);

        // Asynchronous reset in the middle of a countdown
        base = ticks_seen;
        wait_ticks(base, 3);
        mode_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode_in = 1'b0;
        check_eq("rst_count_state", 32'(state), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_mode", 32'(mode), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
